// File: rtl/instr_fetch_reg.sv
// Fetch / instruction-register stage: PC, req/ack instruction read, IR capture and field decode.
// Optional fetch timeout is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch_reg #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        PCWrite,
   input  logic        IRWrite,
   input  logic [31:0] PC_NEXT,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] PC,
   output logic [31:0] OLD_PC,
   output logic [31:0] INSTR,
   output logic [1:0]  OP,
   output logic [2:0]  FUNCT3,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   output logic [4:0]  RD,
   output logic        ILLEGAL,
   output logic        STALL,
   output logic        FETCH_ERR
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] old_pc_q, old_pc_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] instr_q, instr_d;
   logic        mem_req_q, mem_req_d;
   logic        fetch_err_q, fetch_err_d;
   logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;

   // The count holds completed ack-less WAIT cycles; this one is the last allowed.
   assign timeout_hit = (state_q == S_WAIT) && !MEM_ACK && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q != S_WAIT) begin
         tmo_cnt_d = 8'd0;
      end else if (!MEM_ACK) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         tmo_cnt_q <= 8'd0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      old_pc_d    = old_pc_q;
      mem_addr_d  = mem_addr_q;
      instr_d     = instr_q;
      mem_req_d   = mem_req_q;
      fetch_err_d = 1'b0;

      if (PCWrite) begin
         pc_d = PC_NEXT;
      end

      case (state_q)
         S_IDLE, S_VALID: begin
            // Address comes from the current PC, so a same-cycle PCWrite fetches the old PC.
            if (IRWrite) begin
               mem_addr_d = pc_q;
               mem_req_d  = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (MEM_ACK) begin
               instr_d   = MEM_RDATA;
               old_pc_d  = mem_addr_q;
               mem_req_d = 1'b0;
               state_d   = S_VALID;
            end else if (timeout_hit) begin
               instr_d     = NOP;
               old_pc_d    = mem_addr_q;
               mem_req_d   = 1'b0;
               fetch_err_d = 1'b1;
               state_d     = S_VALID;
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         old_pc_q    <= RESET_PC;
         mem_addr_q  <= RESET_PC;
         instr_q     <= NOP;
         mem_req_q   <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         old_pc_q    <= old_pc_d;
         mem_addr_q  <= mem_addr_d;
         instr_q     <= instr_d;
         mem_req_q   <= mem_req_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   logic [1:0] op_w;
   logic       illegal_w;

   always_comb begin
      op_w      = 2'b00;
      illegal_w = 1'b0;
      case (instr_q[6:0])
         OPC_R:                op_w = 2'b00;
         OPC_I_ALU:            op_w = 2'b01;
         OPC_LOAD, OPC_STORE:  op_w = 2'b10;
         OPC_BRANCH:           op_w = 2'b11;
         default:              illegal_w = 1'b1;
      endcase
   end

   assign MEM_REQ   = mem_req_q;
   assign MEM_ADDR  = mem_addr_q;
   assign PC        = pc_q;
   assign OLD_PC    = old_pc_q;
   assign INSTR     = instr_q;
   assign OP        = op_w;
   assign ILLEGAL   = illegal_w;
   assign FUNCT3    = instr_q[14:12];
   assign RS1       = instr_q[19:15];
   assign RS2       = instr_q[24:20];
   assign RD        = instr_q[11:7];
   assign STALL     = (state_q == S_WAIT);
   assign FETCH_ERR = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed-vector bench for instr_fetch_reg (RESET_PC=0x100, TIMEOUT_CYCLES=4).
// Timeout vectors run only when FETCH_TIMEOUT_EN is defined for both files.
module tb_instr_fetch_reg;

   logic        CLK;
   logic        CLR;
   logic        PCWrite;
   logic        IRWrite;
   logic [31:0] PC_NEXT;
   logic [31:0] MEM_RDATA;
   logic        MEM_ACK;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic [31:0] PC;
   logic [31:0] OLD_PC;
   logic [31:0] INSTR;
   logic [1:0]  OP;
   logic [2:0]  FUNCT3;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic [4:0]  RD;
   logic        ILLEGAL;
   logic        STALL;
   logic        FETCH_ERR;

   int n_vec = 0;
   int n_err = 0;
   int stall_cycles;

   instr_fetch_reg #(
      .RESET_PC      (32'h0000_0100),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .PCWrite  (PCWrite),
      .IRWrite  (IRWrite),
      .PC_NEXT  (PC_NEXT),
      .MEM_RDATA(MEM_RDATA),
      .MEM_ACK  (MEM_ACK),
      .MEM_REQ  (MEM_REQ),
      .MEM_ADDR (MEM_ADDR),
      .PC       (PC),
      .OLD_PC   (OLD_PC),
      .INSTR    (INSTR),
      .OP       (OP),
      .FUNCT3   (FUNCT3),
      .RS1      (RS1),
      .RS2      (RS2),
      .RD       (RD),
      .ILLEGAL  (ILLEGAL),
      .STALL    (STALL),
      .FETCH_ERR(FETCH_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic count_stall();
      if (STALL) stall_cycles++;
   endtask

   initial begin
      CLR       = 1'b0;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      PC_NEXT   = 32'h0;
      MEM_RDATA = 32'h0;
      MEM_ACK   = 1'b0;
      #12;

      // Reset values
      check("rst_pc",      PC,        32'h100);
      check("rst_old_pc",  OLD_PC,    32'h100);
      check("rst_addr",    MEM_ADDR,  32'h100);
      check("rst_instr",   INSTR,     32'h13);
      check("rst_op",      {30'b0, OP}, 32'd1);
      check("rst_stall",   {31'b0, STALL}, 32'd0);
      check("rst_req",     {31'b0, MEM_REQ}, 32'd0);
      check("rst_illegal", {31'b0, ILLEGAL}, 32'd0);
      check("rst_ferr",    {31'b0, FETCH_ERR}, 32'd0);
      CLR = 1'b1;
      tick();

      // IRWrite + PCWrite, ack on the next edge with add a0,a0,a1
      stall_cycles = 0;
      IRWrite = 1'b1; PCWrite = 1'b1; PC_NEXT = 32'h104;
      tick();
      IRWrite = 1'b0; PCWrite = 1'b0;
      check("f1_req",   {31'b0, MEM_REQ}, 32'd1);
      check("f1_addr",  MEM_ADDR, 32'h100);
      check("f1_pc",    PC,       32'h104);
      count_stall();
      MEM_ACK = 1'b1; MEM_RDATA = 32'h00B50533;
      tick();
      MEM_ACK = 1'b0;
      count_stall();
      check("f1_stall_cycles", stall_cycles, 32'd1);
      check("f1_req_drop", {31'b0, MEM_REQ}, 32'd0);
      check("f1_instr",  INSTR,  32'h00B50533);
      check("f1_old_pc", OLD_PC, 32'h100);
      check("f1_op",     {30'b0, OP},     32'd0);
      check("f1_funct3", {29'b0, FUNCT3}, 32'd0);
      check("f1_rd",     {27'b0, RD},     32'd10);
      check("f1_rs1",    {27'b0, RS1},    32'd10);
      check("f1_rs2",    {27'b0, RS2},    32'd11);

      // Ack while VALID must be ignored
      MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
      tick();
      MEM_ACK = 1'b0;
      check("stray_ack_instr", INSTR, 32'h00B50533);
      check("stray_ack_stall", {31'b0, STALL}, 32'd0);

      // Three wait states, beq; PC moved and IRWrite pulsed during WAIT
      stall_cycles = 0;
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      count_stall();
      PCWrite = 1'b1; PC_NEXT = 32'h200;
      tick();
      PCWrite = 1'b0;
      count_stall();
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      count_stall();
      check("f2_addr_held", MEM_ADDR, 32'h104);
      check("f2_pc_in_wait", PC, 32'h200);
      tick();
      count_stall();
      MEM_ACK = 1'b1; MEM_RDATA = 32'hFE0508E3;
      tick();
      MEM_ACK = 1'b0;
      count_stall();
      check("f2_stall_cycles", stall_cycles, 32'd4);
      check("f2_instr",   INSTR,  32'hFE0508E3);
      check("f2_old_pc",  OLD_PC, 32'h104);
      check("f2_op",      {30'b0, OP}, 32'd3);
      check("f2_illegal", {31'b0, ILLEGAL}, 32'd0);
      check("f2_req",     {31'b0, MEM_REQ}, 32'd0);

      // Illegal opcode
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      check("f3_addr", MEM_ADDR, 32'h200);
      MEM_ACK = 1'b1; MEM_RDATA = 32'h0000007F;
      tick();
      MEM_ACK = 1'b0;
      check("f3_illegal", {31'b0, ILLEGAL}, 32'd1);
      check("f3_op",      {30'b0, OP}, 32'd0);
      check("f3_old_pc",  OLD_PC, 32'h200);

      // Reset in the second cycle of WAIT, then a late ack
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      tick();
      check("r_stall_before", {31'b0, STALL}, 32'd1);
      #2 CLR = 1'b0;
      #1;
      check("r_req_async", {31'b0, MEM_REQ}, 32'd0);
      check("r_stall_async", {31'b0, STALL}, 32'd0);
      check("r_instr_async", INSTR, 32'h13);
      check("r_pc_async", PC, 32'h100);
      tick();
      CLR = 1'b1;
      tick();
      MEM_ACK = 1'b1; MEM_RDATA = 32'h00000533;
      tick();
      MEM_ACK = 1'b0;
      check("r_late_ack_instr", INSTR, 32'h13);
      check("r_late_ack_stall", {31'b0, STALL}, 32'd0);
      check("r_late_ack_old_pc", OLD_PC, 32'h100);

      // Load a non-NOP word so the timeout's NOP is observable
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      MEM_ACK = 1'b1; MEM_RDATA = 32'h00B50533;
      tick();
      MEM_ACK = 1'b0;
      check("t0_instr", INSTR, 32'h00B50533);

      PCWrite = 1'b1; PC_NEXT = 32'h300;
      tick();
      PCWrite = 1'b0;
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      check("t1_addr", MEM_ADDR, 32'h300);
      tick(); tick(); tick();
      check("t1_stall_3", {31'b0, STALL}, 32'd1);
      check("t1_ferr_3",  {31'b0, FETCH_ERR}, 32'd0);
      tick();
`ifdef FETCH_TIMEOUT_EN
      // Fourth ack-less WAIT cycle: abandoned fetch
      check("t1_ferr",   {31'b0, FETCH_ERR}, 32'd1);
      check("t1_stall",  {31'b0, STALL}, 32'd0);
      check("t1_req",    {31'b0, MEM_REQ}, 32'd0);
      check("t1_instr",  INSTR, 32'h13);
      check("t1_old_pc", OLD_PC, 32'h300);
      tick();
      check("t1_ferr_pulse", {31'b0, FETCH_ERR}, 32'd0);

      // Ack on the fourth WAIT cycle beats the timeout
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      tick(); tick(); tick();
      MEM_ACK = 1'b1; MEM_RDATA = 32'hFE0508E3;
      tick();
      MEM_ACK = 1'b0;
      check("t2_ferr",  {31'b0, FETCH_ERR}, 32'd0);
      check("t2_instr", INSTR, 32'hFE0508E3);
      check("t2_stall", {31'b0, STALL}, 32'd0);
      tick();
      check("t2_ferr_next", {31'b0, FETCH_ERR}, 32'd0);
`else
      // Without the timeout the read stays outstanding until acked
      tick(); tick(); tick(); tick();
      check("nt_stall",  {31'b0, STALL}, 32'd1);
      check("nt_req",    {31'b0, MEM_REQ}, 32'd1);
      check("nt_ferr",   {31'b0, FETCH_ERR}, 32'd0);
      check("nt_instr",  INSTR, 32'h00B50533);
      MEM_ACK = 1'b1; MEM_RDATA = 32'hFE0508E3;
      tick();
      MEM_ACK = 1'b0;
      check("nt_ack_instr", INSTR, 32'hFE0508E3);
      check("nt_ack_old_pc", OLD_PC, 32'h300);
      check("nt_ack_stall", {31'b0, STALL}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
